// File: rtl/fport_pkg.sv
// Shared FPort constants, transmitter state encoding and the frame checksum step.
// The receiver reuses fport_crc_step when it validates incoming frames.
package fport_pkg;

    localparam logic [7:0] FPORT_FRAME_BYTE    = 8'h7E;
    localparam logic [7:0] FPORT_ESCAPE_BYTE   = 8'h7D;
    localparam logic [7:0] FPORT_ESCAPE_XOR    = 8'h20;
    localparam logic [7:0] FPORT_DOWNLINK_LEN  = 8'h08;
    localparam logic [7:0] FPORT_DOWNLINK_TYPE = 8'h81;
    localparam logic [7:0] FPORT_PRIM_DATA     = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        TURNAROUND,
        SEND,
        FINISH
    } fport_tx_state_t;

    // Byte add with end-around carry; the result never exceeds 8 bits.
    function automatic logic [7:0] fport_crc_step(input logic [7:0] sum, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, sum} + {1'b0, b};
        return s[7:0] + {7'd0, s[8]};
    endfunction

    function automatic logic fport_needs_escape(input logic [7:0] b);
        return (b == FPORT_FRAME_BYTE) || (b == FPORT_ESCAPE_BYTE);
    endfunction

endpackage

// File: rtl/fport_uart_tx_byte.sv
// Inverted 8N1 byte serializer: start=1, data bits as ~bit LSB first, stop/idle=0.
// byte_done is asserted on the last clock of the stop bit so a new load can follow immediately.
module fport_uart_tx_byte #(
    parameter int clocks_per_bit = 104
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data_byte,
    output logic       line,
    output logic       busy,
    output logic       byte_done
);

    localparam int              PERIOD_W    = $clog2(clocks_per_bit);
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(clocks_per_bit - 1);
    localparam logic [3:0]      STOP_BIT    = 4'd9;

    logic [PERIOD_W-1:0] period_cnt;
    logic [3:0]          bit_cnt;
    logic [7:0]          shift_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy       <= 1'b0;
            bit_cnt    <= 4'd0;
            period_cnt <= '0;
            shift_q    <= 8'd0;
        end else if (load) begin
            busy       <= 1'b1;
            bit_cnt    <= 4'd0;
            period_cnt <= PERIOD_LAST;
            shift_q    <= data_byte;
        end else if (busy) begin
            if (period_cnt != '0) begin
                period_cnt <= period_cnt - 1'b1;
            end else if (bit_cnt == STOP_BIT) begin
                busy <= 1'b0;
            end else begin
                bit_cnt    <= bit_cnt + 1'b1;
                period_cnt <= PERIOD_LAST;
                // bit 0 of shift_q is always the data bit on the wire
                if (bit_cnt != 4'd0) shift_q <= shift_q >> 1;
            end
        end
    end

    always_comb begin
        byte_done = busy && (bit_cnt == STOP_BIT) && (period_cnt == '0);
        if (!busy)                    line = 1'b0;
        else if (bit_cnt == 4'd0)     line = 1'b1;
        else if (bit_cnt == STOP_BIT) line = 1'b0;
        else                          line = ~shift_q[0];
    end

endmodule

// File: rtl/fport_telemetry_tx.sv
// FPort downlink telemetry transmitter: builds, stuffs and sends one frame per accepted start.
// state      | meaning
// IDLE       | ready, waiting for start
// TURNAROUND | line driven idle for turnaround_bits bit periods
// SEND       | feeding wire bytes (with escapes) to the serializer
// FINISH     | line released, done pulse
module fport_telemetry_tx
    import fport_pkg::*;
#(
    parameter int clock_frequency = 12000000,
    parameter int fport_baudrate  = 115_200,
    parameter int clocks_per_bit  = clock_frequency / fport_baudrate,
    parameter int turnaround_bits = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] app_id,
    input  logic [31:0] data,
    output logic        ready,
    output logic        tx_enable,
    output logic        tx_out,
    output logic        done
);

    localparam int                TA_CLOCKS = turnaround_bits * clocks_per_bit;
    localparam int                TA_W      = $clog2(TA_CLOCKS + 1);
    localparam logic [TA_W-1:0]   TA_LAST   = TA_W'(TA_CLOCKS - 1);
    localparam logic [3:0]        LAST_IDX  = 4'd11;

    fport_tx_state_t state, state_next;

    logic [15:0]     app_id_q;
    logic [31:0]     data_q;
    logic [7:0]      crc_sum;
    logic [3:0]      byte_idx;
    logic            esc_flag;
    logic [TA_W-1:0] ta_cnt;

    logic [7:0] cur_byte, next_byte, ser_byte;
    logic [3:0] next_idx;
    logic       next_esc, ser_load, ser_line, ser_busy, ser_byte_done;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [15:0] a,
                                              input logic [31:0] d, input logic [7:0] sum);
        case (idx)
            4'd1:    return FPORT_DOWNLINK_LEN;
            4'd2:    return FPORT_DOWNLINK_TYPE;
            4'd3:    return FPORT_PRIM_DATA;
            4'd4:    return a[7:0];
            4'd5:    return a[15:8];
            4'd6:    return d[7:0];
            4'd7:    return d[15:8];
            4'd8:    return d[23:16];
            4'd9:    return d[31:24];
            4'd10:   return 8'hFF - sum;
            default: return FPORT_FRAME_BYTE;
        endcase
    endfunction

    always_comb begin
        cur_byte  = frame_byte(byte_idx, app_id_q, data_q, crc_sum);
        next_idx  = byte_idx + 4'd1;
        next_byte = frame_byte(next_idx, app_id_q, data_q, crc_sum);
        // only the opening and closing flags are exempt from stuffing
        next_esc  = (next_idx != LAST_IDX) && fport_needs_escape(next_byte);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        ser_load   = 1'b0;
        ser_byte   = FPORT_FRAME_BYTE;
        case (state)
            IDLE: if (start) state_next = TURNAROUND;
            TURNAROUND: begin
                if (ta_cnt == '0 && !ser_busy) begin
                    ser_load   = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (ser_byte_done) begin
                    if (esc_flag) begin
                        ser_load = 1'b1;
                        ser_byte = cur_byte ^ FPORT_ESCAPE_XOR;
                    end else if (byte_idx == LAST_IDX) begin
                        state_next = FINISH;
                    end else begin
                        ser_load = 1'b1;
                        ser_byte = next_esc ? FPORT_ESCAPE_BYTE : next_byte;
                    end
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // crc_sum absorbs each byte as it is queued, so it is complete before index 10 is built
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            app_id_q <= 16'd0;
            data_q   <= 32'd0;
            crc_sum  <= 8'd0;
            byte_idx <= 4'd0;
            esc_flag <= 1'b0;
            ta_cnt   <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                app_id_q <= app_id;
                data_q   <= data;
                crc_sum  <= 8'd0;
                byte_idx <= 4'd0;
                esc_flag <= 1'b0;
                ta_cnt   <= TA_LAST;
            end
        end else if (state == TURNAROUND) begin
            if (ta_cnt != '0) ta_cnt <= ta_cnt - 1'b1;
        end else if (state == SEND && ser_byte_done) begin
            if (esc_flag) begin
                esc_flag <= 1'b0;
            end else if (byte_idx != LAST_IDX) begin
                byte_idx <= next_idx;
                esc_flag <= next_esc;
                if (next_idx <= 4'd9) crc_sum <= fport_crc_step(crc_sum, next_byte);
            end
        end
    end

    always_comb begin
        ready     = (state == IDLE);
        tx_enable = (state == TURNAROUND) || (state == SEND);
        done      = (state == FINISH);
        tx_out    = (state == SEND) ? ser_line : 1'b0;
    end

    fport_uart_tx_byte #(
        .clocks_per_bit(clocks_per_bit)
    ) u_uart_tx_byte (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (ser_load),
        .data_byte (ser_byte),
        .line      (ser_line),
        .busy      (ser_busy),
        .byte_done (ser_byte_done)
    );

endmodule

// File: tb/tb_fport_telemetry_tx.sv
// Bench for fport_telemetry_tx: a line decoder rebuilds wire bytes and a frame model
// derived from the byte/CRC/stuffing rules supplies the expected sequence and timing.
`timescale 1ns/1ps
module tb_fport_telemetry_tx;

    localparam int CPB   = 12000000 / 115200;
    localparam int LIMIT = 20000;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [15:0] app_id  = 16'd0;
    logic [31:0] data    = 32'd0;
    logic        ready, tx_enable, tx_out, done;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    fport_telemetry_tx dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .app_id    (app_id),
        .data      (data),
        .ready     (ready),
        .tx_enable (tx_enable),
        .tx_out    (tx_out),
        .done      (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- line decoder ----------------
    int         cyc = 0;
    int         en_cyc = 0;
    bit         en_seen = 0;
    logic       prev_line = 0;
    logic [7:0] shreg = 0;
    logic [7:0] mon_q[$];
    int         line_err = 0;
    int         done_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        int off, slot, bitn;
        if (done) done_cnt++;
        if (!tx_enable) begin
            en_seen = 0;
        end else if (!en_seen) begin
            en_seen   = 1;
            en_cyc    = cyc;
            mon_q.delete();
            prev_line = tx_out;
            if (tx_out !== 1'b0) line_err++;
        end else begin
            off = cyc - en_cyc;
            // every edge on the line must fall on a bit-period boundary
            if (tx_out !== prev_line && (off % CPB) != 0) line_err++;
            prev_line = tx_out;
            if (off >= CPB && (off % CPB) == CPB / 2) begin
                slot = off / CPB - 1;
                bitn = slot % 10;
                if (bitn == 0) begin
                    if (tx_out !== 1'b1) line_err++;
                    shreg = 8'd0;
                end else if (bitn <= 8) begin
                    shreg[bitn-1] = ~tx_out;
                end else begin
                    if (tx_out !== 1'b0) line_err++;
                    mon_q.push_back(shreg);
                end
            end
        end
    end

    // ---------------- frame model ----------------
    logic [7:0] exp_q[$];

    function automatic void model_frame(input logic [15:0] a, input logic [31:0] d);
        int         s;
        logic [7:0] lb[12];
        lb[0] = 8'h7E; lb[1] = 8'h08; lb[2] = 8'h81; lb[3] = 8'h10;
        lb[4] = a[7:0];  lb[5] = a[15:8];
        lb[6] = d[7:0];  lb[7] = d[15:8]; lb[8] = d[23:16]; lb[9] = d[31:24];
        s = 0;
        for (int i = 1; i <= 9; i++) begin
            s = s + lb[i];
            s = (s % 256) + (s / 256);
        end
        lb[10] = 8'(255 - s);
        lb[11] = 8'h7E;
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            if (i >= 1 && i <= 10 && (lb[i] == 8'h7E || lb[i] == 8'h7D)) begin
                exp_q.push_back(8'h7D);
                exp_q.push_back(lb[i] ^ 8'h20);
            end else begin
                exp_q.push_back(lb[i]);
            end
        end
    endfunction

    function automatic logic [7:0] rnd_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h7E;
            1:       return 8'h7D;
            default: return 8'($urandom);
        endcase
    endfunction

    // Called and returns at a negedge; the following frame may therefore start back-to-back.
    task automatic run_frame(input string tag, input logic [15:0] a, input logic [31:0] d,
                             input bit disturb);
        int n, done_base, err_base;
        bit got;
        model_frame(a, d);
        done_base = done_cnt;
        err_base  = line_err;
        app_id = a;
        data   = d;
        start  = 1'b1;
        check({tag, " ready_before"}, ready, 1);
        @(posedge clock);
        n   = 0;
        got = 0;
        while (n < LIMIT) begin
            @(negedge clock);
            start = 1'b0;
            if (done) begin
                got = 1;
                break;
            end
            if (n == 200) check({tag, " ready_busy"}, ready, 0);
            if (disturb) begin
                app_id = 16'($urandom);
                data   = $urandom;
                if (n == 3000) start = 1'b1;
            end
            @(posedge clock);
            n++;
        end
        check({tag, " done_seen"}, got, 1);
        check({tag, " done_latency"}, n, (1 + 10 * exp_q.size()) * CPB);
        check({tag, " txen_at_done"}, tx_enable, 0);
        @(negedge clock);
        check({tag, " done_width"}, done, 0);
        check({tag, " ready_after"}, ready, 1);
        check({tag, " done_count"}, done_cnt - done_base, 1);
        check({tag, " line_errors"}, line_err - err_base, 0);
        check({tag, " wire_len"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < mon_q.size()) check($sformatf("%s byte%0d", tag, i), mon_q[i], exp_q[i]);
    endtask

    // Starts a frame back-to-back, then pulls reset while byte 5 is on the wire.
    task automatic reset_mid_frame();
        int n, done_base;
        done_base = done_cnt;
        app_id = 16'($urandom);
        data   = $urandom;
        start  = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        check("rst accepted", tx_enable, 1);
        repeat (3) @(negedge clock);
        n = 0;
        while (mon_q.size() < 5 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        check("rst reach_byte5", (mon_q.size() >= 5), 1);
        repeat ($urandom_range(1, 9 * CPB)) @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst txen", tx_enable, 0);
        check("rst txout", tx_out, 0);
        check("rst done", done, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("rst ready", ready, 1);
        check("rst no_done", done_cnt - done_base, 0);
    endtask

    initial begin
        logic [31:0] d;
        reset_n = 1'b0;
        start   = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("reset txen", tx_enable, 0);
        check("reset txout", tx_out, 0);
        check("reset ready", ready, 1);
        check("reset done", done, 0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);

        run_frame("basic", 16'h5100, 32'h0000_0001, 0);
        run_frame("stuff", 16'h5100, 32'h0000_007E, 0);
        run_frame("crc7d", 16'h7870, 32'h0000_0000, 0);

        d = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
        run_frame("disturb", {rnd_byte(), rnd_byte()}, d, 1);
        reset_mid_frame();

        d = {rnd_byte(), rnd_byte(), rnd_byte(), rnd_byte()};
        run_frame("after_rst", {rnd_byte(), rnd_byte()}, d, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
